// File: rtl/draw_sprite_anim_if.sv
// rtl/draw_sprite_anim_if.sv - VGA timing plus pixel colour bundle passed between drawing stages
`timescale 1ns/1ps
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_anim.sv
// rtl/draw_sprite_anim.sv - animated sprite-sheet overlay with frame-latched position and colour key
`timescale 1ns/1ps
module draw_sprite_anim #(
    parameter int          SPRITE_W        = 32,
    parameter int          SPRITE_H        = 32,
    parameter int          FRAME_COUNT     = 3,
    parameter int          FRAME_TICKS     = 15,
    parameter int          ROM_LATENCY     = 1,
    parameter bit          TRANSPARENT_EN  = 1'b1,
    parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F,
    parameter int          ADDR_W          = $clog2(SPRITE_W*FRAME_COUNT*SPRITE_H),
    parameter int          FRAME_W         = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        xpos,
    input  logic [11:0]        ypos,
    input  logic               visible,
    input  logic               anim_en,
    input  logic [FRAME_W-1:0] frame_sel,
    input  logic [11:0]        rgb_pixel,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [FRAME_W-1:0] frame_idx,
    vga_if.in                  draw_in,
    vga_if.out                 draw_out
);

    localparam int          TICK_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int          FRAME_W1 = FRAME_W + 1;
    localparam logic [31:0] SHEET_W  = 32'(SPRITE_W * FRAME_COUNT);
    localparam logic [31:0] SPR_W32  = 32'(SPRITE_W);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t px;
        logic in_rect;
    } stage_t;

    logic               vsync_q, vsync_d;
    logic [11:0]        xpos_l_q, xpos_l_d;
    logic [11:0]        ypos_l_q, ypos_l_d;
    logic               vis_l_q, vis_l_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    stage_t             dly_q [ROM_LATENCY];
    stage_t             dly_d [ROM_LATENCY];
    vga_t               out_q, out_d;

    logic               frame_evt;
    logic               in_rect;
    logic [12:0]        hc13, vc13, xl13, yl13, col, row;
    logic [ADDR_W-1:0]  addr_calc;
    stage_t             tail;
    logic               show;

    // Position, visibility and animation only move on a vsync rising edge so a frame never tears.
    always_comb begin
        frame_evt = draw_in.vsync && !vsync_q;
        vsync_d   = draw_in.vsync;
        xpos_l_d  = xpos_l_q;
        ypos_l_d  = ypos_l_q;
        vis_l_d   = vis_l_q;
        tick_d    = tick_q;
        frame_d   = frame_q;
        if (frame_evt) begin
            xpos_l_d = xpos;
            ypos_l_d = ypos;
            vis_l_d  = visible;
            if (anim_en) begin
                if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                    tick_d  = '0;
                    frame_d = (frame_q == FRAME_W'(FRAME_COUNT - 1)) ? '0 : frame_q + FRAME_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end else begin
                tick_d  = '0;
                frame_d = ({1'b0, frame_sel} >= FRAME_W1'(FRAME_COUNT)) ? '0 : frame_sel;
            end
        end
    end

    // 13-bit compare keeps xpos_l + SPRITE_W from wrapping back to column 0.
    always_comb begin
        hc13      = {2'b00, draw_in.hcount};
        vc13      = {2'b00, draw_in.vcount};
        xl13      = {1'b0, xpos_l_q};
        yl13      = {1'b0, ypos_l_q};
        col       = hc13 - xl13;
        row       = vc13 - yl13;
        in_rect   = (hc13 >= xl13) && (hc13 < xl13 + 13'(SPRITE_W)) &&
                    (vc13 >= yl13) && (vc13 < yl13 + 13'(SPRITE_H));
        addr_calc = ADDR_W'(32'(row) * SHEET_W + 32'(col) + 32'(frame_q) * SPR_W32);
        pixel_addr = (rst && in_rect) ? addr_calc : '0;
    end

    always_comb begin
        dly_d[0].px.hcount = draw_in.hcount;
        dly_d[0].px.vcount = draw_in.vcount;
        dly_d[0].px.hsync  = draw_in.hsync;
        dly_d[0].px.hblnk  = draw_in.hblnk;
        dly_d[0].px.vsync  = draw_in.vsync;
        dly_d[0].px.vblnk  = draw_in.vblnk;
        dly_d[0].px.rgb    = draw_in.rgb;
        dly_d[0].in_rect   = in_rect;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    always_comb begin
        tail  = dly_q[ROM_LATENCY-1];
        show  = tail.in_rect && vis_l_q && !tail.px.hblnk && !tail.px.vblnk &&
                !(TRANSPARENT_EN && (rgb_pixel == TRANSPARENT_RGB));
        out_d     = tail.px;
        out_d.rgb = show ? rgb_pixel : tail.px.rgb;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q  <= 1'b0;
            xpos_l_q <= '0;
            ypos_l_q <= '0;
            vis_l_q  <= 1'b0;
            tick_q   <= '0;
            frame_q  <= '0;
            out_q    <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            vsync_q  <= vsync_d;
            xpos_l_q <= xpos_l_d;
            ypos_l_q <= ypos_l_d;
            vis_l_q  <= vis_l_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            out_q    <= out_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign frame_idx       = frame_q;
    assign draw_out.hcount = out_q.hcount;
    assign draw_out.vcount = out_q.vcount;
    assign draw_out.hsync  = out_q.hsync;
    assign draw_out.hblnk  = out_q.hblnk;
    assign draw_out.vsync  = out_q.vsync;
    assign draw_out.vblnk  = out_q.vblnk;
    assign draw_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite_anim.sv
// tb/tb_draw_sprite_anim.sv - directed vector bench for draw_sprite_anim
`timescale 1ns/1ps
module tb_draw_sprite_anim;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        visible, anim_en;
    logic [1:0]  frame_sel;
    logic [11:0] rgb_a, rgb_b;
    logic [11:0] addr_a, addr_b;
    logic [1:0]  fidx_a, fidx_b;
    logic        rom_mode = 1'b0;
    int          n_vec = 0;
    int          n_fail = 0;

    vga_if vin();
    vga_if vout_a();
    vga_if vout_b();

    draw_sprite_anim #(.FRAME_TICKS(2), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .visible(visible),
        .anim_en(anim_en), .frame_sel(frame_sel), .rgb_pixel(rgb_a),
        .pixel_addr(addr_a), .frame_idx(fidx_a), .draw_in(vin), .draw_out(vout_a));

    draw_sprite_anim #(.FRAME_TICKS(2), .ROM_LATENCY(1), .TRANSPARENT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .visible(visible),
        .anim_en(anim_en), .frame_sel(frame_sel), .rgb_pixel(rgb_b),
        .pixel_addr(addr_b), .frame_idx(fidx_b), .draw_in(vin), .draw_out(vout_b));

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rgb_a <= rom_mode ? 12'hF0F : addr_a;
        rgb_b <= rom_mode ? 12'hF0F : addr_b;
    end

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic [11:0] bg;
        logic        hb;
        logic [11:0] exp_rgb;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg,
                         input logic hb, input logic vs);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[0];
        vin.hblnk  = hb;
        vin.vsync  = vs;
        vin.vblnk  = 1'b0;
        vin.rgb    = bg;
    endtask

    task automatic filler();
        drive(11'd1500, 11'd700, 12'h000, 1'b1, 1'b0);
    endtask

    task automatic pulse();
        @(negedge clk);
        drive(11'd1500, 11'd700, 12'h000, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        filler();
    endtask

    // One pixel, then filler; output must show the pixel exactly two edges later.
    task automatic probe(input logic [10:0] h, input logic [10:0] v, input logic [11:0] bg,
                         input logic hb, input logic [11:0] exp_a, input logic [11:0] exp_b,
                         input logic [11:0] exp_addr, input string nm);
        @(negedge clk);
        drive(h, v, bg, hb, 1'b0);
        #1;
        chk({nm, " addr"}, 64'(addr_a), 64'(exp_addr));
        @(posedge clk);
        #1;
        chk({nm, " lat1"}, 64'(vout_a.hcount), 64'd1500);
        @(negedge clk);
        filler();
        @(posedge clk);
        #1;
        chk({nm, " rgb"}, 64'(vout_a.rgb), 64'(exp_a));
        chk({nm, " rgb_b"}, 64'(vout_b.rgb), 64'(exp_b));
        chk({nm, " timing"},
            64'({vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.hblnk, vout_a.vsync, vout_a.vblnk}),
            64'({h, v, h[0], hb, 2'b00}));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{11'd100, 11'd50, 12'hA01, 1'b0, 12'h000, 12'd0};
        tbl[1] = '{11'd131, 11'd50, 12'hA02, 1'b0, 12'h01F, 12'd31};
        tbl[2] = '{11'd100, 11'd51, 12'hA03, 1'b0, 12'h060, 12'd96};
        tbl[3] = '{11'd99,  11'd50, 12'hA04, 1'b0, 12'hA04, 12'd0};
        tbl[4] = '{11'd132, 11'd50, 12'hA05, 1'b0, 12'hA05, 12'd0};
        tbl[5] = '{11'd131, 11'd81, 12'hA06, 1'b0, 12'hBBF, 12'd3007};
        tbl[6] = '{11'd100, 11'd82, 12'hA07, 1'b0, 12'hA07, 12'd0};
        tbl[7] = '{11'd115, 11'd49, 12'hA08, 1'b0, 12'hA08, 12'd0};
        tbl[8] = '{11'd110, 11'd60, 12'hA09, 1'b1, 12'hA09, 12'd970};

        rst = 1'b0;
        xpos = 12'd0; ypos = 12'd0; visible = 1'b0; anim_en = 1'b0; frame_sel = 2'd0;
        filler();
        repeat (3) @(posedge clk);
        #1;
        chk("reset out", 64'({vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.hblnk,
                              vout_a.vsync, vout_a.vblnk, vout_a.rgb}), 64'd0);
        chk("reset fidx", 64'(fidx_a), 64'd0);
        chk("reset addr", 64'(addr_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        probe(11'd10, 11'd10, 12'h111, 1'b0, 12'h111, 12'h111, 12'd970, "pre_vsync");

        xpos = 12'd100; ypos = 12'd50; visible = 1'b1;
        pulse();
        for (int i = 0; i < 9; i++) begin
            probe(tbl[i].h, tbl[i].v, tbl[i].bg, tbl[i].hb, tbl[i].exp_rgb, tbl[i].exp_rgb,
                  tbl[i].exp_addr, $sformatf("vec%0d", i));
        end

        anim_en = 1'b1;
        chk("anim f0", 64'(fidx_a), 64'd0);
        pulse();
        chk("anim p1", 64'(fidx_a), 64'd0);
        pulse();
        chk("anim p2", 64'(fidx_a), 64'd1);
        probe(11'd100, 11'd50, 12'hB00, 1'b0, 12'h020, 12'h020, 12'd32, "anim_frame1");
        pulse();
        chk("anim p3", 64'(fidx_a), 64'd1);
        pulse();
        chk("anim p4", 64'(fidx_a), 64'd2);
        pulse();
        chk("anim p5", 64'(fidx_a), 64'd2);
        pulse();
        chk("anim p6", 64'(fidx_a), 64'd0);

        anim_en = 1'b0; frame_sel = 2'd0; xpos = 12'd100; ypos = 12'd290;
        pulse();
        probe(11'd100, 11'd295, 12'hB01, 1'b0, 12'h1E0, 12'h1E0, 12'd480, "tear_before");
        xpos = 12'd200;
        probe(11'd100, 11'd300, 12'hB02, 1'b0, 12'h3C0, 12'h3C0, 12'd960, "tear_old");
        probe(11'd200, 11'd300, 12'hB03, 1'b0, 12'hB03, 12'hB03, 12'd0, "tear_new_early");
        pulse();
        probe(11'd200, 11'd300, 12'hB04, 1'b0, 12'h3C0, 12'h3C0, 12'd960, "tear_new");
        probe(11'd100, 11'd300, 12'hB05, 1'b0, 12'hB05, 12'hB05, 12'd0, "tear_old_gone");

        xpos = 12'd100; ypos = 12'd50;
        pulse();
        rom_mode = 1'b1;
        probe(11'd105, 11'd55, 12'hC01, 1'b0, 12'hC01, 12'hF0F, 12'd485, "key_in");
        probe(11'd90, 11'd55, 12'hC02, 1'b0, 12'hC02, 12'hC02, 12'd0, "key_out");
        rom_mode = 1'b0;

        xpos = 12'd1010;
        pulse();
        probe(11'd1010, 11'd50, 12'hD01, 1'b0, 12'h000, 12'h000, 12'd0, "edge_first");
        probe(11'd1023, 11'd50, 12'hD02, 1'b0, 12'h00D, 12'h00D, 12'd13, "edge_last");
        probe(11'd1009, 11'd50, 12'hD03, 1'b0, 12'hD03, 12'hD03, 12'd0, "edge_left");
        probe(11'd0, 11'd50, 12'hD04, 1'b0, 12'hD04, 12'hD04, 12'd0, "edge_nowrap");
        probe(11'd1030, 11'd50, 12'hD05, 1'b1, 12'hD05, 12'hD05, 12'd20, "edge_blank");

        visible = 1'b0; xpos = 12'd100;
        probe(11'd1015, 11'd52, 12'hE01, 1'b0, 12'h0C5, 12'h0C5, 12'd197, "vis_same_frame");
        pulse();
        probe(11'd105, 11'd55, 12'hE02, 1'b0, 12'hE02, 12'hE02, 12'd485, "vis_off");

        visible = 1'b1; frame_sel = 2'd2;
        pulse();
        chk("sel2", 64'(fidx_a), 64'd2);
        probe(11'd100, 11'd50, 12'hE03, 1'b0, 12'h040, 12'h040, 12'd64, "sel2_pix");
        frame_sel = 2'd3;
        pulse();
        chk("sel3", 64'(fidx_a), 64'd0);

        frame_sel = 2'd2;
        pulse();
        chk("pre_reset fidx", 64'(fidx_a), 64'd2);
        @(negedge clk);
        drive(11'd105, 11'd55, 12'hF01, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async out", 64'({vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.hblnk,
                              vout_a.vsync, vout_a.vblnk, vout_a.rgb}), 64'd0);
        chk("async fidx", 64'(fidx_a), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        filler();
        probe(11'd100, 11'd50, 12'hF02, 1'b0, 12'hF02, 12'hF02, 12'd0, "post_rst_old");
        probe(11'd10, 11'd10, 12'hF03, 1'b0, 12'hF03, 12'hF03, 12'd970, "post_rst_hidden");
        pulse();
        chk("post_rst fidx", 64'(fidx_a), 64'd2);
        probe(11'd100, 11'd50, 12'hF04, 1'b0, 12'h040, 12'h040, 12'd64, "post_rst_draw");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
